dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port data memory between the core's load/store path and a debug/loader port. It sits between the core datapath (ALU address, register-file store data, writeback read data) and the data memory. It grants at most one access per cycle using round-robin priority, returns read data one cycle after grant, and drives a stall to the core while its request waits. An optional bounded lock lets the loader perform uninterrupted bursts.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- BURST_MAX, 8, maximum consecutive cycles the loader may hold a lock (≥1)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous active-high reset
- core_req  in  1  core access request
- core_we  in  1  1 = store, 0 = load
- core_addr  in  AW  core byte address
- core_wdata  in  DW  core store data
- core_gnt  out  1  core access performed this cycle
- core_stall  out  1  core_req & ~core_gnt
- core_rvalid  out  1  core read data valid (cycle after load grant)
- core_rdata  out  DW  core read data
- ld_req, ld_we, ld_addr, ld_wdata  in  1/1/AW/DW  loader request, same meaning as core
- ld_lock  in  1  loader requests burst lock
- ld_gnt, ld_rvalid, ld_rdata  out  1/1/DW  loader grant / read valid / read data
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, combinational from mem_addr
- locked  out  1  arbiter in LOCKED state

## Operation
- Registered state: state {ARB, LOCKED}, last_gnt (0 = core, 1 = loader), burst_cnt, per-port rvalid and rdata registers.
- ARB: only one requester → granted. Both → port ≠ last_gnt granted. last_gnt updates to granted port at the edge.
- Grant is combinational from req and registered state; mem_we/mem_addr/mem_wdata mux from granted port; no grant → mem_we = 0, mem_addr/mem_wdata = 0.
- Granted load: mem_rdata captured into that port's rdata at the edge; rvalid high exactly one cycle. Granted store: rvalid stays 0; memory commits at the edge.
- Non-granted requester holds req/we/addr/wdata stable until it sees gnt high.
- rdata registers hold last value when rvalid is 0.
- LOCKED (macro only): entered when ld_gnt & ld_lock in ARB; burst_cnt ← 1. In LOCKED only loader may be granted; core_gnt = 0 even if loader idle. burst_cnt increments every cycle. Exit to ARB at the edge where ld_lock = 0 or burst_cnt = BURST_MAX; on exit last_gnt ← 1 so core wins next contention.
- Reset (any time, including mid-burst): state ARB, last_gnt 1 (core wins first contention), burst_cnt 0, all rvalid 0, all rdata 0, locked 0; gnt and mem_we forced 0 while reset asserted. In-flight read data discarded.

## Timing
- Grant latency: 0 cycles uncontended; ≤1 extra cycle under contention in ARB; ≤BURST_MAX extra cycles behind a lock.
- Read latency: rvalid/rdata one cycle after the grant cycle.
- Back-to-back grants to the same port allowed when the other port is idle.
- Simultaneous ld_lock deassert and core_req: exit edge and core grant in the following cycle.
- core_stall is combinational, valid in the same cycle as core_req.

## Configuration
- DMEM_ARB_LOCK_EN defined: ld_lock honoured, LOCKED state and burst_cnt present.
- Not defined: ld_lock ignored, state is always ARB, locked tied 0, burst_cnt removed; pure round-robin.

## Test plan
- Reset, core load addr 0x10 alone, mem holds 0xDEADBEEF → core_gnt same cycle, core_rvalid=1 and core_rdata=0xDEADBEEF next cycle, stall 0.
- Both request every cycle after reset → grants alternate core, loader, core, loader; each stall ≤1 cycle.
- Loader store 0x20 ← 0x12345678 while core idle, then core load 0x20 → core_rdata 0x12345678.
- (LOCK_EN) loader ld_lock held 20 cycles with core_req high, BURST_MAX=8 → locked for 8 cycles, core granted the next cycle; without macro → alternating grants.
- Reset asserted mid-lock with pending load → locked, rvalids, gnts, mem_we all 0 immediately; after release core wins first contention.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin core/loader data memory arbiter (optional burst lock: DMEM_ARB_LOCK_EN)
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int BURST_MAX = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_stall,
    output logic          core_rvalid,
    output logic [DW-1:0] core_rdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          ld_lock,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          locked
);

    localparam int CW = $clog2(BURST_MAX + 1);

    logic last_gnt;     // 0 = core served last, 1 = loader served last
    logic in_lock;
    logic grant_core;
    logic grant_ld;

`ifdef DMEM_ARB_LOCK_EN
    typedef enum logic {ARB, LOCKED} state_t;

    state_t        state;
    logic [CW-1:0] burst_cnt;

    assign in_lock = (state == LOCKED);
    assign locked  = in_lock;

    // Burst lock FSM: enter on a locked loader grant, leave when the loader drops the lock or the burst budget is spent
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB;
            burst_cnt <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (grant_ld && ld_lock) begin
                        state     <= LOCKED;
                        burst_cnt <= CW'(1);
                    end
                end
                LOCKED: begin
                    if (!ld_lock || burst_cnt == CW'(BURST_MAX)) begin
                        state     <= ARB;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + CW'(1);
                    end
                end
                default: begin
                    state     <= ARB;
                    burst_cnt <= '0;
                end
            endcase
        end
    end
`else
    logic unused_cfg;

    assign in_lock    = 1'b0;
    assign locked     = 1'b0;
    assign unused_cfg = ld_lock | (CW == 0);
`endif

    // Grant decision: lock gives the loader exclusive use, otherwise the port not served last wins a tie
    always_comb begin
        grant_core = 1'b0;
        grant_ld   = 1'b0;
        if (!reset) begin
            if (in_lock) begin
                grant_ld = ld_req;
            end else if (core_req && ld_req) begin
                grant_core = last_gnt;
                grant_ld   = ~last_gnt;
            end else begin
                grant_core = core_req;
                grant_ld   = ld_req;
            end
        end
    end

    // Memory port mux driven from whichever port holds the grant, zeros when idle
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_core) begin
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (grant_ld) begin
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    assign core_gnt   = grant_core;
    assign ld_gnt     = grant_ld;
    assign core_stall = core_req & ~grant_core;

    // Round-robin history; a lock always leaves the loader marked as last so the core wins next contention
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt <= 1'b1;
        end else if (grant_core) begin
            last_gnt <= 1'b0;
        end else if (grant_ld || in_lock) begin
            last_gnt <= 1'b1;
        end
    end

    // Read return: capture memory data for a granted load, valid for exactly the following cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
            ld_rvalid   <= 1'b0;
            ld_rdata    <= '0;
        end else begin
            core_rvalid <= grant_core & ~core_we;
            ld_rvalid   <= grant_ld & ~ld_we;
            if (grant_core && !core_we) begin
                core_rdata <= mem_rdata;
            end
            if (grant_ld && !ld_we) begin
                ld_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter against a behavioural model
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BM = 8;
`ifdef DMEM_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif
    localparam int WAIT_LIMIT = LOCK_EN ? BM + 1 : 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_req, core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt, core_stall, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          ld_req, ld_we, ld_lock;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt, ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          locked;

    dmem_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_lock(ld_lock),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .locked(locked)
    );

    always #5 clk = ~clk;

    // Physical memory seen by the DUT: 64 words, combinational read, write on the edge
    logic [31:0] phys_mem [64];
    logic        mem_clr;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) phys_mem[i] <= '0;
        end else if (mem_we) begin
            phys_mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = phys_mem[mem_addr[7:2]];

    // Reference model state
    logic [31:0] ref_mem [64];
    bit          core_turn;      // core wins the next tie
    bit          m_locked;
    int          burst_len;      // cycles the current burst has lasted
    bit          e_crv, e_lrv;
    logic [31:0] e_crd, e_lrd;
    bit          prev_cg, prev_lg;
    int          core_wait;
    bit          dut_cg, dut_locked;
    int          total, bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: inputs already driven after the falling edge; check, update model, go to next falling edge
    task automatic step();
        bit          cg, lg, we;
        logic [31:0] a, w;
        #1;
        if (reset) begin
            core_turn = 1'b1;
            m_locked  = 1'b0;
            burst_len = 0;
            e_crv = 1'b0; e_lrv = 1'b0;
            e_crd = '0;   e_lrd = '0;
        end
        cg = 1'b0;
        lg = 1'b0;
        if (!reset) begin
            if (m_locked) begin
                lg = ld_req;
            end else if (core_req && ld_req) begin
                if (core_turn) cg = 1'b1; else lg = 1'b1;
            end else begin
                cg = core_req;
                lg = ld_req;
            end
        end
        we = 1'b0; a = '0; w = '0;
        if (cg) begin we = core_we; a = core_addr; w = core_wdata; end
        if (lg) begin we = ld_we;   a = ld_addr;   w = ld_wdata;   end

        check("core_gnt",    core_gnt,    cg);
        check("ld_gnt",      ld_gnt,      lg);
        check("core_stall",  core_stall,  core_req && !cg);
        check("mem_we",      mem_we,      we);
        check("mem_addr",    mem_addr,    a);
        check("mem_wdata",   mem_wdata,   w);
        check("locked",      locked,      m_locked);
        check("core_rvalid", core_rvalid, e_crv);
        check("core_rdata",  core_rdata,  e_crd);
        check("ld_rvalid",   ld_rvalid,   e_lrv);
        check("ld_rdata",    ld_rdata,    e_lrd);
        dut_cg     = core_gnt;
        dut_locked = locked;

        if (core_req && !reset) begin
            if (cg) begin
                check("core_wait_bound", core_wait <= WAIT_LIMIT, 1);
                core_wait = 0;
            end else begin
                core_wait++;
            end
        end else begin
            core_wait = 0;
        end

        if (!reset) begin
            e_crv = cg && !core_we;
            e_lrv = lg && !ld_we;
            if (e_crv) e_crd = ref_mem[core_addr[7:2]];
            if (e_lrv) e_lrd = ref_mem[ld_addr[7:2]];
            if (cg && core_we) ref_mem[core_addr[7:2]] = core_wdata;
            if (lg && ld_we)   ref_mem[ld_addr[7:2]]   = ld_wdata;
            if (cg) core_turn = 1'b0;
            if (lg) core_turn = 1'b1;
            if (LOCK_EN) begin
                if (m_locked) begin
                    if (!ld_lock || burst_len == BM) begin
                        m_locked  = 1'b0;
                        core_turn = 1'b1;
                    end else begin
                        burst_len++;
                    end
                end else if (lg && ld_lock) begin
                    m_locked  = 1'b1;
                    burst_len = 1;
                end
            end
        end
        prev_cg = cg;
        prev_lg = lg;
        @(negedge clk);
    endtask

    task automatic set_core(input bit req, input bit we_i, input logic [31:0] addr, input logic [31:0] data);
        core_req = req; core_we = we_i; core_addr = addr; core_wdata = data;
    endtask

    task automatic set_ld(input bit req, input bit we_i, input logic [31:0] addr, input logic [31:0] data);
        ld_req = req; ld_we = we_i; ld_addr = addr; ld_wdata = data;
    endtask

    initial begin
        int run, first_run;
        bit prev_lock_seen;
        total = 0; bad = 0;
        core_turn = 1'b1; m_locked = 1'b0; burst_len = 0;
        e_crv = 1'b0; e_lrv = 1'b0; e_crd = '0; e_lrd = '0;
        prev_cg = 1'b0; prev_lg = 1'b0; core_wait = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        reset = 1'b1; mem_clr = 1'b1; ld_lock = 1'b0;
        set_core(0, 0, 0, 0);
        set_ld(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        step();                                  // reset state
        reset = 1'b0;

        // Loader store DEADBEEF at 0x10, then lone core load
        set_ld(1, 1, 32'h10, 32'hDEADBEEF);
        step();
        set_ld(0, 0, 0, 0);
        set_core(1, 0, 32'h10, 0);
        step();
        check("rd_deadbeef_valid", core_rvalid, 1);
        check("rd_deadbeef_data", core_rdata, 32'hDEADBEEF);
        set_core(0, 0, 0, 0);
        step();

        // Both request every cycle: grants alternate
        set_core(1, 0, 32'h10, 0);
        set_ld(1, 0, 32'h14, 0);
        step();
        for (int i = 0; i < 8; i++) begin
            bit last_c;
            last_c = dut_cg;
            step();
            check("alternate", dut_cg, !last_c);
        end
        set_core(0, 0, 0, 0);
        set_ld(0, 0, 0, 0);
        step();

        // Loader store then core load of 0x20
        set_ld(1, 1, 32'h20, 32'h12345678);
        step();
        set_ld(0, 0, 0, 0);
        set_core(1, 0, 32'h20, 0);
        step();
        check("rd_12345678", core_rdata, 32'h12345678);
        set_core(0, 0, 0, 0);
        step();

        // Lock held 20 cycles with core contending
        set_core(1, 0, 32'h30, 0);
        set_ld(1, 1, 32'h34, 32'hA5A5_0001);
        ld_lock = 1'b1;
        run = 0; first_run = 0; prev_lock_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dut_locked) run++;
            if (!dut_locked && prev_lock_seen && first_run == 0) first_run = run;
            prev_lock_seen = dut_locked;
            if (core_req && prev_cg) set_core(1, 0, 32'h30, 0);
        end
        check("lock_run_len", first_run, LOCK_EN ? BM : 0);
        ld_lock = 1'b0;
        set_core(0, 0, 0, 0);
        set_ld(0, 0, 0, 0);
        repeat (2) step();

        // Reset in the middle of a lock with a loader load in flight
        ld_lock = 1'b1;
        set_ld(1, 0, 32'h20, 0);
        set_core(1, 0, 32'h10, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (LOCK_EN && dut_locked) break;
        end
        reset = 1'b1;
        step();
        check("mid_reset_locked", dut_locked, 0);
        step();
        reset = 1'b0;
        ld_lock = 1'b0;
        step();
        check("post_reset_core_wins", dut_cg, 1);
        set_core(0, 0, 0, 0);
        set_ld(0, 0, 0, 0);
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!(core_req && !prev_cg) || reset) begin
                set_core($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                         32'($urandom_range(0, 63)) << 2, $urandom);
            end
            if (!(ld_req && !prev_lg) || reset) begin
                set_ld($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                       32'($urandom_range(0, 63)) << 2, $urandom);
            end
            if ($urandom_range(0, 5) == 0) ld_lock = !ld_lock;
            reset = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        set_core(0, 0, 0, 0);
        set_ld(0, 0, 0, 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
